clint_timer: RTL and testbench

- Memory-mapped machine timer and software-interrupt slave on the system bus.
- Sits directly downstream of the bus interconnect and consumes its slave-side transactions: wdata, addr, bstart, tsize and ss, plus ttype.
- Holds a 64-bit mtime counter with programmable prescaler, a 64-bit mtimecmp register and an msip bit.
- Drives timer_irq and soft_irq to the core.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/clint_timer_pkg.sv | 21 ++
 rtl/clint_timer_if.sv | 30 +++
 rtl/timer_prescaler.sv | 38 +++
 rtl/clint_timer.sv | 137 +++++++++++++
 tb/tb_clint_timer.sv | 204 ++++++++++++++++++++
 6 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// bus_pkg : transfer size / type encodings shared by all system-bus agents
// Revision : 1.0
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } tsize_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

endpackage
`default_nettype wire

// File: rtl/clint_timer_pkg.sv
`default_nettype none
// ============================================================================
// clint_timer_pkg : register offsets and field positions of the machine timer
// Revision : 1.0
// ============================================================================
package clint_timer_pkg;

    localparam logic [4:0] C_OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] C_OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] C_OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] C_OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] C_OFF_MSIP        = 5'h10;
    localparam logic [4:0] C_OFF_CTRL        = 5'h14;

    localparam int unsigned C_CTRL_EN_BIT  = 0;
    localparam int unsigned C_CTRL_DIV_LSB = 8;

    localparam logic [63:0] C_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/clint_timer_if.sv
`default_nettype none
// ============================================================================
// clint_timer_if : slave-side system-bus signals between interconnect and timer
// Revision : 1.0
// ============================================================================
interface clint_timer_if;
    import bus_pkg::*;

    logic        ss;
    logic        bstart;
    ttype_e      ttype;
    tsize_e      tsize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;
    logic        berror;

    modport master (
        output ss, bstart, ttype, tsize, addr, wdata,
        input  rdata, bdone, berror
    );

    modport slave (
        input  ss, bstart, ttype, tsize, addr, wdata,
        output rdata, bdone, berror
    );

endinterface
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// timer_prescaler : emits one tick every div+1 enabled cycles
// Revision : 1.0
// ============================================================================
module timer_prescaler (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       en_i,
    input  wire logic [7:0] div_i,
    input  wire logic       clr_i,
    output logic            tick_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        tick_o  = en_i && (count_q == div_i);
        count_d = count_q;
        // The tick of a clearing cycle still uses the old count and divider.
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tick_o ? 8'd0 : count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clint_timer.sv
`default_nettype none
// ============================================================================
// clint_timer : memory-mapped 64-bit machine timer and software interrupt
// Revision : 1.0
// ============================================================================
module clint_timer
    import bus_pkg::*;
    import clint_timer_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'd0,
    parameter logic       EN_RESET  = 1'b1
) (
    input  wire logic     bclk,
    input  wire logic     brst,
    clint_timer_if.slave  bus,
    output logic          timer_irq,
    output logic          soft_irq
);

    logic [63:0] mtime_q,     mtime_d;
    logic [63:0] mtimecmp_q,  mtimecmp_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;
    logic [31:0] rdata_q,     rdata_d;
    logic [7:0]  div_q,       div_d;
    logic        en_q,        en_d;
    logic        msip_q,      msip_d;
    logic        bdone_q,     bdone_d;
    logic        berror_q,    berror_d;
    logic        irq_q,       irq_d;

    logic        accept;
    logic        err;
    logic        wr;
    logic        rd;
    logic [4:0]  offset;
    logic        tick;
    logic        ctrl_clr;
    logic        unused_addr;

    assign unused_addr = ^bus.addr[31:5];

    always_comb begin
        offset   = bus.addr[4:0];
        accept   = bus.ss && bus.bstart;
        err      = (bus.tsize != WORD) || (offset[1:0] != 2'b00) || (offset > C_OFF_CTRL);
        wr       = accept && !err && (bus.ttype == WRITE);
        rd       = accept && !err && (bus.ttype == READ);
        ctrl_clr = wr && (offset == C_OFF_CTRL);
    end

    timer_prescaler u_prescaler (
        .clk    (bclk),
        .rst    (brst),
        .en_i   (en_q),
        .div_i  (div_q),
        .clr_i  (ctrl_clr),
        .tick_o (tick)
    );

    always_comb begin
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        hi_shadow_d = hi_shadow_q;
        msip_d      = msip_q;
        en_d        = en_q;
        div_d       = div_q;
        rdata_d     = '0;
        bdone_d     = accept;
        berror_d    = accept && err;
        irq_d       = (mtime_q >= mtimecmp_q);

        // A bus write to either mtime half replaces the increment for that cycle.
        if (wr) begin
            case (offset)
                C_OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], bus.wdata};
                C_OFF_MTIME_HI:    mtime_d = {bus.wdata, mtime_q[31:0]};
                C_OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = bus.wdata;
                C_OFF_MTIMECMP_HI: mtimecmp_d[63:32] = bus.wdata;
                C_OFF_MSIP:        msip_d = bus.wdata[0];
                C_OFF_CTRL: begin
                    en_d  = bus.wdata[C_CTRL_EN_BIT];
                    div_d = bus.wdata[C_CTRL_DIV_LSB +: 8];
                end
                default: ;
            endcase
        end

        if (rd) begin
            case (offset)
                C_OFF_MTIME_LO: begin
                    rdata_d     = mtime_q[31:0];
                    hi_shadow_d = mtime_q[63:32];
                end
                C_OFF_MTIME_HI:    rdata_d = hi_shadow_q;
                C_OFF_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                C_OFF_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                C_OFF_MSIP:        rdata_d = {31'd0, msip_q};
                C_OFF_CTRL:        rdata_d = {16'd0, div_q, 7'd0, en_q};
                default:           rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge bclk) begin
        if (brst) begin
            mtime_q     <= '0;
            mtimecmp_q  <= C_MTIMECMP_RESET;
            hi_shadow_q <= '0;
            msip_q      <= 1'b0;
            en_q        <= EN_RESET;
            div_q       <= DIV_RESET;
            rdata_q     <= '0;
            bdone_q     <= 1'b0;
            berror_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            hi_shadow_q <= hi_shadow_d;
            msip_q      <= msip_d;
            en_q        <= en_d;
            div_q       <= div_d;
            rdata_q     <= rdata_d;
            bdone_q     <= bdone_d;
            berror_q    <= berror_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.bdone  = bdone_q;
    assign bus.berror = berror_q;
    assign timer_irq  = irq_q;
    assign soft_irq   = msip_q;

endmodule
`default_nettype wire

// File: tb/tb_clint_timer.sv
`default_nettype none
// ============================================================================
// tb_clint_timer : self-checking bench for clint_timer
// Revision : 1.0
// ============================================================================
module tb_clint_timer;
    import bus_pkg::*;

    logic bclk = 1'b0;
    logic brst = 1'b1;
    logic timer_irq;
    logic soft_irq;

    clint_timer_if bus_if ();

    clint_timer #(
        .DIV_RESET (8'd0),
        .EN_RESET  (1'b1)
    ) dut (
        .bclk      (bclk),
        .brst      (brst),
        .bus       (bus_if),
        .timer_irq (timer_irq),
        .soft_irq  (soft_irq)
    );

    always #5 bclk = ~bclk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    typedef struct {
        ttype_e      t;
        tsize_e      s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[15];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every bdone pops one expectation, idle cycles must be quiet.
    always @(negedge bclk) begin
        if (mon_en) begin
            if (bus_if.bdone === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bdone: got bdone=1, expected no pending transaction");
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_rdata"},  64'(bus_if.rdata),  64'(mon_e.rdata));
                    check({mon_e.name, "_berror"}, 64'(bus_if.berror), 64'(mon_e.err));
                end
            end else begin
                check("idle_rdata_berror", 64'({bus_if.rdata, bus_if.berror}), 64'd0);
            end
        end
    end

    task automatic xact(input ttype_e t, input tsize_e s, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input string nm);
        bus_if.ss     = 1'b1;
        bus_if.bstart = 1'b1;
        bus_if.ttype  = t;
        bus_if.tsize  = s;
        bus_if.addr   = a;
        bus_if.wdata  = d;
        sb.push_back('{rdata: er, err: ee, name: nm});
        @(posedge bclk);
        @(negedge bclk);
        bus_if.ss     = 1'b0;
        bus_if.bstart = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge bclk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{WRITE, BYTE, 32'h10, 32'h1,         32'h0,         1'b1};
        vt[1]  = '{READ,  WORD, 32'h10, 32'h0,         32'h0,         1'b0};
        vt[2]  = '{READ,  WORD, 32'h02, 32'h0,         32'h0,         1'b1};
        vt[3]  = '{WRITE, WORD, 32'h0A, 32'h0,         32'h0,         1'b1};
        vt[4]  = '{READ,  WORD, 32'h08, 32'h0,         32'hD,         1'b0};
        vt[5]  = '{WRITE, WORD, 32'h18, 32'hFFFF,      32'h0,         1'b1};
        vt[6]  = '{READ,  WORD, 32'h18, 32'h0,         32'h0,         1'b1};
        vt[7]  = '{READ,  WORD, 32'h0C, 32'h0,         32'h1,         1'b0};
        vt[8]  = '{READ,  WORD, 32'h14, 32'h0,         32'h1,         1'b0};
        vt[9]  = '{WRITE, WORD, 32'h14, 32'hFFFF_FF00, 32'h0,         1'b0};
        vt[10] = '{READ,  WORD, 32'h14, 32'h0,         32'h0000_FF00, 1'b0};
        vt[11] = '{WRITE, WORD, 32'h08, 32'hA5A5_5A5A, 32'h0,         1'b0};
        vt[12] = '{READ,  WORD, 32'h08, 32'h0,         32'hA5A5_5A5A, 1'b0};
        vt[13] = '{WRITE, WORD, 32'h10, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vt[14] = '{READ,  WORD, 32'h10, 32'h0,         32'h1,         1'b0};

        bus_if.ss     = 1'b0;
        bus_if.bstart = 1'b0;
        bus_if.ttype  = READ;
        bus_if.tsize  = WORD;
        bus_if.addr   = '0;
        bus_if.wdata  = '0;

        idle(3);
        check("rst_rdata",     64'(bus_if.rdata),  64'd0);
        check("rst_bdone",     64'(bus_if.bdone),  64'd0);
        check("rst_berror",    64'(bus_if.berror), 64'd0);
        check("rst_timer_irq", 64'(timer_irq),     64'd0);
        check("rst_soft_irq",  64'(soft_irq),      64'd0);
        mon_en = 1'b1;
        brst   = 1'b0;

        // div=0: one increment per cycle since reset release
        idle(10);
        xact(READ,  WORD, 32'h00, 32'h0,   32'd10, 1'b0, "mtime_lo_after10");
        xact(WRITE, WORD, 32'h14, 32'h301, 32'd0,  1'b0, "ctrl_div3");
        xact(READ,  WORD, 32'h00, 32'h0,   32'd12, 1'b0, "mtime_lo_base");
        idle(40);
        xact(READ,  WORD, 32'h00, 32'h0,   32'd22, 1'b0, "mtime_lo_div3");

        // wrap from all-ones and coherent LO/HI pair
        xact(WRITE, WORD, 32'h14, 32'h1,         32'd0, 1'b0, "ctrl_div0");
        xact(WRITE, WORD, 32'h00, 32'hFFFF_FFFF, 32'd0, 1'b0, "mtime_lo_ones");
        xact(WRITE, WORD, 32'h04, 32'hFFFF_FFFF, 32'd0, 1'b0, "mtime_hi_ones");
        idle(2);
        xact(READ,  WORD, 32'h00, 32'h0, 32'd1, 1'b0, "wrap_lo");
        xact(READ,  WORD, 32'h04, 32'h0, 32'd0, 1'b0, "wrap_hi");
        xact(WRITE, WORD, 32'h04, 32'd5, 32'd0, 1'b0, "mtime_hi_5");
        xact(READ,  WORD, 32'h04, 32'h0, 32'd0, 1'b0, "stale_hi");
        xact(READ,  WORD, 32'h00, 32'h0, 32'd4, 1'b0, "fresh_lo");
        xact(READ,  WORD, 32'h04, 32'h0, 32'd5, 1'b0, "fresh_hi");

        // timer interrupt timing
        xact(WRITE, WORD, 32'h04, 32'd0,  32'd0, 1'b0, "mtime_hi_0");
        xact(WRITE, WORD, 32'h0C, 32'd0,  32'd0, 1'b0, "cmp_hi_0");
        xact(WRITE, WORD, 32'h08, 32'd13, 32'd0, 1'b0, "cmp_lo_13");
        idle(5);
        check("irq_before_match", 64'(timer_irq), 64'd0);
        idle(1);
        check("irq_after_match", 64'(timer_irq), 64'd1);
        xact(WRITE, WORD, 32'h0C, 32'd1, 32'd0, 1'b0, "cmp_hi_1");
        check("irq_at_cmp_write", 64'(timer_irq), 64'd1);
        idle(1);
        check("irq_cleared", 64'(timer_irq), 64'd0);

        // error cases and back-to-back register traffic
        for (int i = 0; i < 15; i++) begin
            xact(vt[i].t, vt[i].s, vt[i].a, vt[i].d, vt[i].er, vt[i].ee, $sformatf("vec%0d", i));
        end
        check("soft_irq_set", 64'(soft_irq), 64'd1);

        // reset coinciding with an accept edge suppresses the response
        brst          = 1'b1;
        bus_if.ss     = 1'b1;
        bus_if.bstart = 1'b1;
        bus_if.ttype  = READ;
        bus_if.tsize  = WORD;
        bus_if.addr   = 32'h10;
        @(posedge bclk);
        @(negedge bclk);
        check("abort_bdone",     64'(bus_if.bdone),  64'd0);
        check("abort_rdata",     64'(bus_if.rdata),  64'd0);
        check("abort_berror",    64'(bus_if.berror), 64'd0);
        check("abort_timer_irq", 64'(timer_irq),     64'd0);
        check("abort_soft_irq",  64'(soft_irq),      64'd0);
        brst          = 1'b0;
        bus_if.ss     = 1'b0;
        bus_if.bstart = 1'b0;
        xact(READ, WORD, 32'h14, 32'h0, 32'h1,         1'b0, "post_rst_ctrl");
        xact(READ, WORD, 32'h10, 32'h0, 32'h0,         1'b0, "post_rst_msip");
        xact(READ, WORD, 32'h0C, 32'h0, 32'hFFFF_FFFF, 1'b0, "post_rst_cmp_hi");

        idle(3);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
